fifo8_drain: RTL and testbench

//   Read-side controller for the 8-entry FIFO_8 queue. Shadows FIFO occupancy by snooping
//   the producer's write strobe and issues ren only when a pop is safe. Captures dout one

---
 rtl/fifo8_drain_pkg.sv | 22 ++
 rtl/fifo8_drain_obuf.sv | 78 +++++++
 rtl/fifo8_drain.sv | 96 +++++++++
 tb/tb_fifo8_drain.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo8_drain_pkg.sv
// Shared constants and helpers for the FIFO_8 read-side drain controller.
package fifo8_drain_pkg;

    localparam int DW          = 8;
    localparam int DEPTH       = 8;
    localparam int CW          = 4;
    localparam int OB          = 2;
    localparam int FIFO_RD_LAT = 1;

    // What the shadow occupancy counter does in a given cycle.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_POP  = 2'd1,
        LVL_PUSH = 2'd2,
        LVL_DROP = 2'd3
    } lvl_op_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fifo8_drain_obuf.sv
// Two-entry FIFO-ordered holding buffer that turns captured FIFO_8 reads into a valid/ready stream.
module drain_obuf
    import fifo8_drain_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem_rd [OB];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign do_pop  = pop && (cnt_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((cnt_q != 2'(OB)) || do_pop);

    generate
        for (genvar gi = 0; gi < OB; gi++) begin : g_entry
            logic [W-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (do_push && (wr_ptr_q == 1'(gi)))
                    entry_d = push_data;
            end

            always_ff @(posedge clk) begin
                if (rst)
                    entry_q <= '0;
                else
                    entry_q <= entry_d;
            end

            assign mem_rd[gi] = entry_q;
        end
    endgenerate

    // Single-bit pointers wrap naturally for the two-entry buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push)
            wr_ptr_d = ~wr_ptr_q;
        if (do_pop)
            rd_ptr_d = ~rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_data = mem_rd[rd_ptr_q];
    assign cnt       = cnt_q;

endmodule

// File: rtl/fifo8_drain.sv
// Read-side controller for FIFO_8: shadows occupancy from the write strobe, issues safe pops
// and re-emits the read data as a valid/ready stream.
module fifo8_drain
    import fifo8_drain_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_wen,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_error,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] level,
    output logic [7:0]    ovf_cnt,
    output logic          proto_err
);

    localparam logic [CW-1:0] LEVEL_FULL = CW'(DEPTH);

    logic [CW-1:0] level_q, level_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          proto_err_q, proto_err_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    ob_cnt;
    logic [2:0]    outstanding;
    logic          capture;
    logic          xfer;
    lvl_op_e       lvl_op;

    // Reads already in flight count against buffer space so a captured word always has a slot.
    assign outstanding = {1'b0, ob_cnt} + {2'b00, inflight_q};
    assign fifo_ren    = !rst && (level_q != '0) && !fifo_wen && (outstanding < 3'(OB));

    assign capture = inflight_q && !fifo_error;
    assign xfer    = m_valid && m_ready;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (fifo_ren)
            lvl_op = LVL_POP;
        else if (fifo_wen && (level_q != LEVEL_FULL))
            lvl_op = LVL_PUSH;
        else if (fifo_wen)
            lvl_op = LVL_DROP;
    end

    always_comb begin
        level_d     = level_q;
        ovf_cnt_d   = ovf_cnt_q;
        proto_err_d = proto_err_q;
        inflight_d  = fifo_ren;
        case (lvl_op)
            LVL_POP:  level_d   = level_q - CW'(1);
            LVL_PUSH: level_d   = level_q + CW'(1);
            LVL_DROP: ovf_cnt_d = sat_inc8(ovf_cnt_q);
            default:  level_d   = level_q;
        endcase
        // An error on our own read means the shadow level disagrees with the real FIFO.
        if (inflight_q && fifo_error)
            proto_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= '0;
            ovf_cnt_q   <= 8'd0;
            proto_err_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            level_q     <= level_d;
            ovf_cnt_q   <= ovf_cnt_d;
            proto_err_q <= proto_err_d;
            inflight_q  <= inflight_d;
        end
    end

    drain_obuf #(
        .W(DW)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (xfer),
        .head_data (m_data),
        .cnt       (ob_cnt)
    );

    assign m_valid   = (ob_cnt != 2'd0);
    assign level     = level_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fifo8_drain.sv
// Directed and randomized checks of fifo8_drain against a behavioural FIFO_8 plus stream model.
module tb_fifo8_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_wen;
    logic       fifo_ren;
    logic [7:0] fifo_dout;
    logic       fifo_error;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] level;
    logic [7:0] ovf_cnt;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: real FIFO contents, read in flight, words owed downstream.
    logic [7:0] fq[$];
    logic [7:0] ob_m[$];
    logic [7:0] got_q[$];
    logic       fl_v, fl_err;
    logic [7:0] fl_d;
    int         shadow;
    int         ovf_m;
    logic       proto_m;
    int         ren_count;

    always #5 clk = ~clk;

    fifo8_drain dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_wen   (fifo_wen),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .fifo_error (fifo_error),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level),
        .ovf_cnt    (ovf_cnt),
        .proto_err  (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d, input logic rdy,
                         output logic ren_o, output logic mv_o, output logic [7:0] md_o);
        logic       ren_s;
        logic       xfer;
        logic [7:0] dout_n;
        logic       err_n;
        rst      = r;
        fifo_wen = w;
        m_ready  = rdy;
        #2;
        ren_s = fifo_ren;
        ren_o = ren_s;
        mv_o  = m_valid;
        md_o  = m_data;
        dout_n = fifo_dout;
        err_n  = 1'b0;
        if (r) begin
            chk("ren_in_rst", 32'(ren_s), 32'd0);
            fq.delete(); ob_m.delete();
            fl_v = 1'b0; fl_err = 1'b0; shadow = 0; ovf_m = 0; proto_m = 1'b0;
            dout_n = 8'h00;
        end else begin
            chk("level", 32'(level), 32'(shadow));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
            chk("proto_err", 32'(proto_err), 32'(proto_m));
            chk("ren_vs_wen", 32'(ren_s && w), 32'd0);
            chk("outstanding", 32'(ob_m.size() + int'(fl_v)), 32'(ob_m.size() + int'(fl_v) <= 2 ? ob_m.size() + int'(fl_v) : 2));
            if (shadow == 0)
                chk("ren_when_empty", 32'(ren_s), 32'd0);
            chk("m_valid", 32'(m_valid), 32'(ob_m.size() != 0));
            if (ob_m.size() != 0)
                chk("m_data", 32'(m_data), 32'(ob_m[0]));
            xfer = (ob_m.size() != 0) && rdy;
            if (xfer) begin
                got_q.push_back(m_data);
                void'(ob_m.pop_front());
            end
            if (fl_v) begin
                if (fl_err) proto_m = 1'b1;
                else        ob_m.push_back(fl_d);
            end
            fl_v = ren_s;
            fl_err = 1'b0;
            if (ren_s) begin
                ren_count++;
                shadow--;
                if (fq.size() == 0) begin
                    fl_err = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    fl_d   = fq.pop_front();
                    dout_n = fl_d;
                end
            end else if (w) begin
                if (shadow < 8) shadow++;
                else if (ovf_m < 255) ovf_m++;
                if (fq.size() < 8) fq.push_back(d);
                else err_n = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        fifo_dout  = dout_n;
        fifo_error = err_n;
    endtask

    initial begin
        logic       ren_o, mv_o;
        logic [7:0] md_o, held;
        int         ren_at, mv_at, n;
        logic       stable;

        rst = 1'b1; fifo_wen = 1'b0; m_ready = 1'b0; fifo_dout = 8'h00; fifo_error = 1'b0;
        fl_v = 1'b0; fl_err = 1'b0; fl_d = 8'h00; shadow = 0; ovf_m = 0; proto_m = 1'b0; ren_count = 0;

        // Reset then idle
        cycle(1, 0, 8'h00, 0, ren_o, mv_o, md_o);
        cycle(1, 0, 8'h00, 0, ren_o, mv_o, md_o);
        cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("rst_m_data", 32'(md_o), 32'd0);
        chk("rst_m_valid", 32'(mv_o), 32'd0);
        chk("rst_ren", 32'(ren_o), 32'd0);
        $display("reset: level=%0d m_valid=%0b ren=%0b proto_err=%0b", level, mv_o, ren_o, proto_err);

        // Basic drain with latency measurement
        got_q.delete();
        cycle(0, 1, 8'h11, 1, ren_o, mv_o, md_o);
        cycle(0, 1, 8'h22, 1, ren_o, mv_o, md_o);
        cycle(0, 1, 8'h33, 1, ren_o, mv_o, md_o);
        ren_at = -1; mv_at = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
            if (ren_o && ren_at < 0) ren_at = i;
            if (mv_o && mv_at < 0) mv_at = i;
        end
        chk("first_ren_after_wen", 32'(ren_at), 32'd0);
        chk("ren_to_valid", 32'(mv_at - ren_at), 32'd2);
        chk("drain_cnt", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("drain_d0", 32'(got_q[0]), 32'h11);
            chk("drain_d1", 32'(got_q[1]), 32'h22);
            chk("drain_d2", 32'(got_q[2]), 32'h33);
        end
        chk("drain_level", 32'(level), 32'd0);
        $display("basic drain: %0d words, ren->valid %0d cycles", got_q.size(), mv_at - ren_at);

        // Writes every other cycle while draining
        got_q.delete();
        for (int i = 0; i < 16; i++)
            cycle(0, (i % 2) == 0, 8'($urandom), 1, ren_o, mv_o, md_o);
        for (int i = 0; i < 12; i++)
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("collision_cnt", 32'(got_q.size()), 32'd8);
        $display("collision: %0d words delivered", got_q.size());

        // Backpressure: fill, stall, release
        got_q.delete();
        for (int i = 0; i < 8; i++)
            cycle(0, 1, 8'(8'hA0 + i), 0, ren_o, mv_o, md_o);
        ren_count = 0;
        stable = 1'b1;
        held = 8'h00;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 8'h00, 0, ren_o, mv_o, md_o);
            if (mv_o && i > 3 && md_o !== held) stable = 1'b0;
            held = md_o;
        end
        chk("bp_reads", 32'(ren_count), 32'd2);
        chk("bp_level", 32'(level), 32'd6);
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_head", 32'(held), 32'hA0);
        for (int i = 0; i < 24; i++)
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("bp_cnt", 32'(got_q.size()), 32'd8);
        $display("backpressure: reads during stall=2? %0d, delivered %0d", 2, got_q.size());

        // Overflow from empty, then saturation
        for (int i = 0; i < 10; i++)
            cycle(0, 1, 8'($urandom), 0, ren_o, mv_o, md_o);
        chk("ovf_10", 32'(ovf_cnt), 32'd2);
        for (int i = 0; i < 260; i++)
            cycle(0, 1, 8'($urandom), 0, ren_o, mv_o, md_o);
        chk("ovf_sat", 32'(ovf_cnt), 32'd255);
        chk("ovf_proto", 32'(proto_err), 32'd0);
        for (int i = 0; i < 24; i++)
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        $display("overflow: ovf_cnt=%0d proto_err=%0b", ovf_cnt, proto_err);

        // Randomized traffic
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) < 7, ren_o, mv_o, md_o);
            n++;
        end
        for (int i = 0; i < 30; i++)
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("rand_empty", 32'(level), 32'd0);
        $display("random: %0d cycles, level=%0d", n, level);

        // FIFO reset on its own: our later reads hit an empty FIFO
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 8'(8'h50 + i), 0, ren_o, mv_o, md_o);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 8'h00, 0, ren_o, mv_o, md_o);
        fq.delete();
        for (int i = 0; i < 12; i++)
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("proto_set", 32'(proto_err), 32'd1);
        $display("desync: proto_err=%0b level=%0d", proto_err, level);

        // Reset in the cycle after a read is issued
        cycle(1, 0, 8'h00, 0, ren_o, mv_o, md_o);
        cycle(0, 1, 8'hC3, 0, ren_o, mv_o, md_o);
        ren_at = -1;
        for (int i = 0; i < 5 && ren_at < 0; i++) begin
            cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
            if (ren_o) ren_at = i;
        end
        chk("midrd_ren_seen", 32'(ren_at >= 0), 32'd1);
        cycle(1, 0, 8'h00, 1, ren_o, mv_o, md_o);
        cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("midrd_valid", 32'(mv_o), 32'd0);
        chk("midrd_level", 32'(level), 32'd0);
        cycle(0, 0, 8'h00, 1, ren_o, mv_o, md_o);
        chk("midrd_valid2", 32'(mv_o), 32'd0);
        $display("mid-read reset: m_valid=%0b level=%0d", mv_o, level);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
